// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the memory-access stage.
//   - opcode / funct constants used by the stage's instruction classifier
//   - mem-stage state enum {ST_IDLE, ST_REQ}
//   - packed writeback record {we, dest, data} and decoder result bundle
package mips_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB   = 6'h22;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } wb_rec_t;

    typedef struct packed {
        logic             is_load;
        logic             is_store;
        logic             writes;
        logic [REG_W-1:0] dest;
        logic             ovf_trap;
    } dec_t;

endpackage

// File: rtl/mips_mem_stage_if.sv
// Data-memory request/acknowledge bus.
//   master (mem stage): drives mem_req, mem_we, mem_addr, mem_wdata
//   slave  (memory)   : drives mem_ack, mem_rdata (rdata valid in the ack cycle)
interface mips_mem_stage_if;
    import mips_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_decode.sv
// Combinational instruction classifier for the memory stage.
//   instr    : executed instruction word
//   ovf_flag : ALU overflow flag (ex_flags[0])
//   dec_c    : {is_load, is_store, writes, dest, ovf_trap}; dest is 0 when
//              the instruction does not write a register
module mem_decode
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic               ovf_flag,
    output dec_t               dec_c
);

    logic [OP_W-1:0]  op;
    logic [OP_W-1:0]  funct;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             unused_fields;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];

    // rs and shamt play no part in writeback classification
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        dec_c = '0;
        case (op)
            OP_RTYPE: begin
                dec_c.writes   = 1'b1;
                dec_c.dest     = rd;
                dec_c.ovf_trap = ovf_flag & ((funct == FN_ADD) | (funct == FN_SUB));
            end
            OP_ADDI: begin
                dec_c.writes   = 1'b1;
                dec_c.dest     = rt;
                dec_c.ovf_trap = ovf_flag;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec_c.writes = 1'b1;
                dec_c.dest   = rt;
            end
            OP_LW: begin
                dec_c.is_load = 1'b1;
                dec_c.writes  = 1'b1;
                dec_c.dest    = rt;
            end
            OP_SW: begin
                dec_c.is_store = 1'b1;
            end
            default: begin
                dec_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mem_stage.sv
// MIPS memory-access stage: performs lw/sw over a req/ack handshake with a
// variable-latency memory and emits one writeback record per accepted bundle.
//   clk, reset      : clock, asynchronous active-high reset
//   ex_valid/ready  : execute-stage handshake; ready drops while an access is open
//   ex_instr/result/store_data/flags : executed bundle (result is the byte address for lw/sw)
//   mem_bus         : data-memory master port (mips_mem_stage_if.master)
//   wb_valid/we/dest/data : one-cycle writeback record
//   ovf_err, align_err    : exception pulses coincident with wb_valid
// Build option MEM_ALIGN_CHECK_EN: misaligned lw/sw are trapped (align_err) instead
// of being issued with the address forced to a word boundary.
module mips_mem_stage
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [INSTR_W-1:0]  ex_instr,
    input  logic [DATA_W-1:0]   ex_result,
    input  logic [DATA_W-1:0]   ex_store_data,
    input  logic [2:0]          ex_flags,
    mips_mem_stage_if.master    mem_bus,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [REG_W-1:0]    wb_dest,
    output logic [DATA_W-1:0]   wb_data,
    output logic                ovf_err,
    output logic                align_err
);

    dec_t             dec_c;
    wb_rec_t          rec_c;
    logic             is_mem_c;
    logic             misalign_c;
    logic             unused_flags;

    mem_state_e       state;
    wb_rec_t          wb_q;
    logic             pend_we;
    logic [REG_W-1:0] pend_dest;

    mem_decode u_decode (
        .instr    (ex_instr),
        .ovf_flag (ex_flags[0]),
        .dec_c    (dec_c)
    );

    // only the overflow flag influences this stage
    assign unused_flags = ^ex_flags[2:1];

    assign is_mem_c = dec_c.is_load | dec_c.is_store;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = is_mem_c & (ex_result[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    // Writeback record for a bundle retired without a memory access
    always_comb begin
        rec_c      = '0;
        rec_c.we   = dec_c.writes & (dec_c.dest != REG_W'(0)) & ~dec_c.ovf_trap & ~misalign_c;
        rec_c.dest = dec_c.dest;
        rec_c.data = ex_result;
    end

    // Stage FSM; every output is a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            ex_ready          <= 1'b1;
            mem_bus.mem_req   <= 1'b0;
            mem_bus.mem_we    <= 1'b0;
            mem_bus.mem_addr  <= DATA_W'(0);
            mem_bus.mem_wdata <= DATA_W'(0);
            wb_valid          <= 1'b0;
            wb_q              <= '0;
            ovf_err           <= 1'b0;
            align_err         <= 1'b0;
            pend_we           <= 1'b0;
            pend_dest         <= REG_W'(0);
        end else begin
            wb_valid  <= 1'b0;
            ovf_err   <= 1'b0;
            align_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ex_valid && ex_ready) begin
                        if (is_mem_c && !misalign_c) begin
                            state             <= ST_REQ;
                            ex_ready          <= 1'b0;
                            mem_bus.mem_req   <= 1'b1;
                            mem_bus.mem_we    <= dec_c.is_store;
                            mem_bus.mem_addr  <= {ex_result[DATA_W-1:2], 2'b00};
                            mem_bus.mem_wdata <= ex_store_data;
                            pend_we           <= rec_c.we;
                            pend_dest         <= rec_c.dest;
                        end else begin
                            wb_valid  <= 1'b1;
                            wb_q      <= rec_c;
                            ovf_err   <= dec_c.ovf_trap;
                            align_err <= misalign_c;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_bus.mem_ack) begin
                        state           <= ST_IDLE;
                        ex_ready        <= 1'b1;
                        mem_bus.mem_req <= 1'b0;
                        mem_bus.mem_we  <= 1'b0;
                        wb_valid        <= 1'b1;
                        wb_q.we         <= pend_we;
                        wb_q.dest       <= pend_dest;
                        // stores retire with a zero data field
                        wb_q.data       <= mem_bus.mem_we ? DATA_W'(0) : mem_bus.mem_rdata;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_we   = wb_q.we;
    assign wb_dest = wb_q.dest;
    assign wb_data = wb_q.data;

endmodule

// File: tb/tb_mips_mem_stage.sv
// Self-checking bench for mips_mem_stage: directed cases plus randomized
// bundles checked against a behavioural model with a word-array memory.
module tb_mips_mem_stage;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_flags;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        ovf_err;
    logic        align_err;

    mips_mem_stage_if mem_bus ();

    mips_mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_instr      (ex_instr),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_flags      (ex_flags),
        .mem_bus       (mem_bus),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .ovf_err       (ovf_err),
        .align_err     (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        ovf;
        logic        align;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [64];
    logic [31:0] mem_arr [64];

    // responder control / expected bus contents for the open access
    int          mem_wait = 0;
    logic        force_ack = 1'b0;
    logic [31:0] exp_addr = '0;
    logic        exp_mwe = 1'b0;
    logic [31:0] exp_wdata = '0;

    function automatic logic [31:0] mk_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference: what the register file should see for this bundle, and when
    task automatic model(input logic [31:0] instr, res, sd, input logic [2:0] fl,
                         input int acc_cyc, input int wt, output exp_t e, output logic goes_mem);
        logic [5:0] op;
        logic [5:0] fn;
        logic       writes;
        logic [4:0] dest;
        logic       ovf;
        int         word;
        op = instr[31:26];
        fn = instr[5:0];
        writes = 1'b0;
        dest = 5'd0;
        ovf = 1'b0;
        if (op == 6'h00) begin
            writes = 1'b1;
            dest = instr[15:11];
            ovf = fl[0] && (fn == 6'h20 || fn == 6'h22);
        end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23}) begin
            writes = 1'b1;
            dest = instr[20:16];
            ovf = fl[0] && (op == 6'h08);
        end
        e.we    = writes && (dest != 5'd0) && !ovf;
        e.dest  = dest;
        e.data  = res;
        e.ovf   = ovf;
        e.align = 1'b0;
        goes_mem = (op == 6'h23) || (op == 6'h2B);
`ifdef MEM_ALIGN_CHECK_EN
        if (goes_mem && res[1:0] != 2'b00) begin
            goes_mem = 1'b0;
            e.we = 1'b0;
            e.align = 1'b1;
        end
`endif
        if (goes_mem) begin
            word = int'(res[7:2]);
            if (op == 6'h23) e.data = ref_mem[word];
            else ref_mem[word] = sd;
            e.cyc = acc_cyc + 1 + wt;
        end else begin
            e.cyc = acc_cyc;
        end
    endtask

    // Present a bundle, hold it until accepted, then record what should follow
    task automatic issue(input logic [31:0] instr, res, sd, input logic [2:0] fl, input int wt);
        exp_t e;
        logic gm;
        int   guard;
        guard = 0;
        @(negedge clk);
        ex_valid = 1'b1;
        ex_instr = instr;
        ex_result = res;
        ex_store_data = sd;
        ex_flags = fl;
        while (!ex_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ex_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            ex_valid = 1'b0;
            return;
        end
        mem_wait = wt;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        model(instr, res, sd, fl, cyc, wt, e, gm);
        if (gm) begin
            exp_addr  = {res[31:2], 2'b00};
            exp_mwe   = (instr[31:26] == 6'h2B);
            exp_wdata = sd;
        end
        exp_q.push_back(e);
    endtask

    // Memory responder: acks after mem_wait wait cycles, checks the request is stable
    initial begin
        int   cnt;
        logic busy;
        int   idx;
        cnt = 0;
        busy = 1'b0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                mem_bus.mem_ack = 1'b1;
                mem_bus.mem_rdata = $urandom;
            end else if (!reset && mem_bus.mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                end
                check("mem_addr", 64'(mem_bus.mem_addr), 64'(exp_addr));
                check("mem_we", 64'(mem_bus.mem_we), 64'(exp_mwe));
                if (exp_mwe) check("mem_wdata", 64'(mem_bus.mem_wdata), 64'(exp_wdata));
                check("ex_ready_in_req", 64'(ex_ready), 64'd0);
                if (cnt == mem_wait) begin
                    mem_bus.mem_ack = 1'b1;
                    idx = int'(mem_bus.mem_addr[7:2]);
                    if (mem_bus.mem_we) begin
                        mem_arr[idx] = mem_bus.mem_wdata;
                        mem_bus.mem_rdata = $urandom;
                    end else begin
                        mem_bus.mem_rdata = mem_arr[idx];
                    end
                end else begin
                    mem_bus.mem_ack = 1'b0;
                    mem_bus.mem_rdata = $urandom;
                end
                cnt++;
            end else begin
                busy = 1'b0;
                mem_bus.mem_ack = 1'b0;
            end
        end
    end

    // Writeback monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    check("wb_spurious", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("wb_we", 64'(wb_we), 64'(mon_e.we));
                    check("ovf_err", 64'(ovf_err), 64'(mon_e.ovf));
                    check("align_err", 64'(align_err), 64'(mon_e.align));
                    if (mon_e.we) begin
                        check("wb_dest", 64'(wb_dest), 64'(mon_e.dest));
                        check("wb_data", 64'(wb_data), 64'(mon_e.data));
                    end
                end
            end else if (ovf_err || align_err) begin
                check("err_without_wb", 64'({ovf_err, align_err}), 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [5:0] r_fns [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
    logic [5:0] i_ops [7] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
    logic [5:0] x_ops [6] = '{6'h04, 6'h05, 6'h10, 6'h11, 6'h2F, 6'h3F};

    initial begin
        int          prev;
        int          guard;
        int          k;
        logic [4:0]  rs, rt, rd;
        logic [31:0] res, sd, addr;
        logic [2:0]  fl;
        int          wt;

        reset = 1'b1;
        ex_valid = 1'b0;
        ex_instr = '0;
        ex_result = '0;
        ex_store_data = '0;
        ex_flags = '0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        check("rst_mem_req", 64'(mem_bus.mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_bus.mem_wdata), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_we", 64'(wb_we), 64'd0);
        check("rst_wb_dest", 64'(wb_dest), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_ovf_err", 64'(ovf_err), 64'd0);
        check("rst_align_err", 64'(align_err), 64'd0);
        #2 reset = 1'b0;

        // ALU pass-through, back-to-back accepts
        issue(mk_r(5'd1, 5'd2, 5'd3, 6'h21), 32'h0000_0007, 32'h0, 3'b000, 0);
        prev = cyc;
        for (int i = 0; i < 4; i++) begin
            issue(mk_r(5'd1, 5'd2, 5'(i + 8), 6'h21), 32'h100 + 32'(i), 32'h0, 3'b000, 0);
            check("b2b_accept_gap", 64'(cyc - prev), 64'd1);
            prev = cyc;
        end

        // load with zero wait, store with three wait cycles, read-back of the store
        issue(mk_i(6'h23, 5'd0, 5'd5, 16'h0010), 32'h0000_0010, 32'h0, 3'b000, 0);
        issue(mk_i(6'h2B, 5'd0, 5'd6, 16'h0020), 32'h0000_0020, 32'h0000_1234, 3'b000, 3);
        issue(mk_i(6'h23, 5'd0, 5'd7, 16'h0020), 32'h0000_0020, 32'h0, 3'b000, 1);

        // overflow trap versus non-trapping addu
        issue(mk_r(5'd1, 5'd2, 5'd4, 6'h20), 32'h8000_0000, 32'h0, 3'b001, 0);
        issue(mk_r(5'd1, 5'd2, 5'd4, 6'h21), 32'h8000_0000, 32'h0, 3'b001, 0);

        // reset in the middle of an access
        issue(mk_i(6'h23, 5'd0, 5'd9, 16'h0040), 32'h0000_0040, 32'h0, 3'b000, 20);
        @(negedge clk);
        check("mid_req_high", 64'(mem_bus.mem_req), 64'd1);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async_req_drop", 64'(mem_bus.mem_req), 64'd0);
        check("rst_async_ready", 64'(ex_ready), 64'd1);
        @(negedge clk);
        #1 reset = 1'b0;
        force_ack = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("late_ack_req", 64'(mem_bus.mem_req), 64'd0);
            check("late_ack_wb", 64'(wb_valid), 64'd0);
        end
        force_ack = 1'b0;

        // misaligned load: trapped or word-aligned depending on the build
        issue(mk_i(6'h23, 5'd0, 5'd11, 16'h0013), 32'h0000_0013, 32'h0, 3'b000, 0);
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        check("align_no_req", 64'(mem_bus.mem_req), 64'd0);
`endif

        // randomized bundles
        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 9);
            rs = 5'($urandom);
            rt = 5'($urandom);
            rd = 5'($urandom);
            fl = 3'($urandom);
            res = $urandom;
            sd = $urandom;
            wt = $urandom_range(0, 4);
            addr = {24'h0, 6'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
            case (k)
                0, 1: issue(mk_r(rs, rt, rd, r_fns[$urandom_range(0, 6)]), res, sd, fl, wt);
                2, 3: issue(mk_i(i_ops[$urandom_range(0, 6)], rs, rt, 16'($urandom)), res, sd, fl, wt);
                4, 5, 6: issue(mk_i(6'h23, rs, rt, 16'($urandom)), addr, sd, fl, wt);
                7, 8: issue(mk_i(6'h2B, rs, rt, 16'($urandom)), addr, sd, fl, wt);
                default: issue(mk_i(x_ops[$urandom_range(0, 5)], rs, rt, 16'($urandom)), res, sd, fl, wt);
            endcase
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
